// File: rtl/muldiv_pkg.sv
// Shared types and operand helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_XLEN = 32;

    typedef logic [DEF_XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Operand is negative only when it is interpreted as signed.
    function automatic logic op_is_neg(input word_t v, input logic is_signed);
        return is_signed & v[DEF_XLEN-1];
    endfunction

    function automatic word_t op_abs(input word_t v, input logic is_signed);
        return op_is_neg(v, is_signed) ? word_t'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and the muldiv unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic         req_valid;
    logic         req_ready;
    muldiv_ctrl_t ctrl;
    word_t        in [1:0];
    logic         rsp_valid;
    logic         rsp_ready;
    word_t        out;
    logic         busy;

    modport master (
        output req_valid, ctrl, in, rsp_ready,
        input  req_ready, rsp_valid, out, busy
    );

    modport slave (
        input  req_valid, ctrl, in, rsp_ready,
        output req_ready, rsp_valid, out, busy
    );

endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit; mul and div share one 64-bit accumulator.
// Define MULDIV_FAST_MUL_EN to complete all multiplies in one cycle with a 33x33 multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_t        state_q, state_d;
    muldiv_ctrl_t         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0]    acc_q, acc_d;
    word_t                opb_q, opb_d;
    logic                 neg_q, neg_d;
    word_t                out_q, out_d;

    logic [XLEN:0]        mul_sum;
    logic [XLEN:0]        div_trial;
    logic [2*XLEN-1:0]    mul_step;
    logic [2*XLEN-1:0]    div_step;
    logic [2*XLEN-1:0]    acc_step;

    word_t                in_a, in_b;
    logic                 sgn_a, sgn_b;
    word_t                mag_a, mag_b;
    logic                 neg_a, neg_b;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;
    logic [2*XLEN-1:0]        fast_res;
`endif

    // Results come out of the accumulator as unsigned magnitudes; signs are applied here.
    function automatic word_t finish_result(input muldiv_ctrl_t op,
                                            input logic [2*XLEN-1:0] acc,
                                            input logic neg);
        logic [2*XLEN-1:0] sacc;
        word_t             res;
        sacc = neg ? -acc : acc;
        res  = '0;
        case (op)
            MUL:                 res = sacc[XLEN-1:0];
            MULH, MULHSU, MULHU: res = sacc[2*XLEN-1:XLEN];
            DIV, DIVU:           res = neg ? word_t'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
            REM, REMU:           res = neg ? word_t'(-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
            default:             res = '0;
        endcase
        return res;
    endfunction

    // Shift-add: acc = {partial_hi, multiplier_remaining}; restoring div: acc = {rem, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_step  = ctrl_q[2] ? div_step : mul_step;
    end

    always_comb begin
        in_a  = bus.in[0];
        in_b  = bus.in[1];
        sgn_a = bus.ctrl inside {MULH, MULHSU, DIV, REM};
        sgn_b = bus.ctrl inside {MULH, DIV, REM};
        mag_a = op_abs(in_a, sgn_a);
        mag_b = op_abs(in_b, sgn_b);
        neg_a = op_is_neg(in_a, sgn_a);
        neg_b = op_is_neg(in_b, sgn_b);
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fast_a    = {sgn_a & in_a[XLEN-1], in_a};
        fast_b    = {sgn_b & in_b[XLEN-1], in_b};
        fast_prod = fast_a * fast_b;
        fast_res  = fast_prod[2*XLEN-1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        out_d   = out_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    ctrl_d  = bus.ctrl;
                    acc_d   = {{XLEN{1'b0}}, mag_a};
                    opb_d   = mag_b;
                    cnt_d   = CNT_W'(XLEN);
                    state_d = CALC;
                    case (bus.ctrl)
                        MUL, MULH, MULHSU, MULHU: begin
                            neg_d = neg_a ^ neg_b;
`ifdef MULDIV_FAST_MUL_EN
                            out_d   = (bus.ctrl == MUL) ? fast_res[XLEN-1:0]
                                                        : fast_res[2*XLEN-1:XLEN];
                            state_d = DONE;
`endif
                        end
                        DIV, DIVU: begin
                            neg_d = neg_a ^ neg_b;
                            if (in_b == '0) begin
                                out_d   = '1;
                                state_d = DONE;
                            end else if (bus.ctrl == DIV && in_a == {1'b1, {(XLEN-1){1'b0}}}
                                         && in_b == '1) begin
                                out_d   = in_a;
                                state_d = DONE;
                            end
                        end
                        REM, REMU: begin
                            neg_d = neg_a;
                            if (in_b == '0) begin
                                out_d   = in_a;
                                state_d = DONE;
                            end else if (bus.ctrl == REM && in_a == {1'b1, {(XLEN-1){1'b0}}}
                                         && in_b == '1) begin
                                out_d   = '0;
                                state_d = DONE;
                            end
                        end
                        default: begin
                            out_d   = '0;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = finish_result(ctrl_q, acc_step, neg_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush kills whatever is in flight, including a request offered this cycle.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ctrl_d  = ctrl_q;
            acc_d   = acc_q;
            opb_d   = opb_q;
            neg_d   = neg_q;
            out_d   = out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            out_q   <= out_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.out       = out_q;

endmodule
